// File: rtl/multdiv_issue_if.sv
// Request, mult/div unit and writeback signals of the multdiv issue block.
// master: the issue block itself; slave: the pipeline and unit around it.
interface multdiv_issue_if;
  logic        op_valid;
  logic        op_is_div;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [4:0]  op_rd;
  logic        op_ready;
  logic        busy;
  logic        flush;
  logic        unit_start;
  logic        unit_is_div;
  logic [31:0] unit_a;
  logic [31:0] unit_b;
  logic [31:0] unit_result;
  logic        unit_exception;
  logic        unit_rdy;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_exception;
  logic        wb_ready;

  modport master (
    input  op_valid, op_is_div, operand_a, operand_b, op_rd, flush,
    input  unit_result, unit_exception, unit_rdy, wb_ready,
    output op_ready, busy, unit_start, unit_is_div, unit_a, unit_b,
    output wb_valid, wb_data, wb_rd, wb_exception
  );

  modport slave (
    output op_valid, op_is_div, operand_a, operand_b, op_rd, flush,
    output unit_result, unit_exception, unit_rdy, wb_ready,
    input  op_ready, busy, unit_start, unit_is_div, unit_a, unit_b,
    input  wb_valid, wb_data, wb_rd, wb_exception
  );
endinterface

// File: rtl/multdiv_issue.sv
// Issue/writeback sequencer for an external multi-cycle mult/div unit:
// accepts one op, starts the unit, waits with a timeout, then holds the result.
module multdiv_issue #(
  parameter int unsigned TIMEOUT = 40
) (
  input logic            clk,
  input logic            reset_n,
  multdiv_issue_if.master bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [5:0] CNT_LAST = 6'(TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        is_div_q, is_div_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] data_q, data_d;
  logic        exc_q, exc_d;
  logic        accept;

  // op_ready is forced low while reset is asserted.
  assign bus.op_ready    = reset_n && (state_q == IDLE) && !bus.flush;
  assign accept          = bus.op_valid && bus.op_ready;
  assign bus.busy        = (state_q != IDLE);
  assign bus.unit_start  = (state_q == START) && !bus.flush;
  assign bus.unit_is_div = is_div_q;
  assign bus.unit_a      = a_q;
  assign bus.unit_b      = b_q;
  assign bus.wb_valid    = (state_q == DONE);
  assign bus.wb_data     = data_q;
  assign bus.wb_rd       = rd_q;
  assign bus.wb_exception = exc_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    is_div_d = is_div_q;
    rd_d     = rd_q;
    data_d   = data_q;
    exc_d    = exc_q;

    if (bus.flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_d      = bus.operand_a;
            b_d      = bus.operand_b;
            is_div_d = bus.op_is_div;
            rd_d     = bus.op_rd;
            // Divide by zero never reaches the unit.
            if (bus.op_is_div && (bus.operand_b == 32'd0)) begin
              state_d = DONE;
              data_d  = 32'd0;
              exc_d   = 1'b1;
            end else begin
              state_d = START;
            end
          end
        end
        START: begin
          cnt_d   = 6'd0;
          state_d = WAIT;
        end
        WAIT: begin
          cnt_d = cnt_q + 6'd1;
          if (bus.unit_rdy) begin
            state_d = DONE;
            data_d  = bus.unit_result;
            exc_d   = bus.unit_exception;
          end else if (cnt_q == CNT_LAST) begin
            state_d = DONE;
            data_d  = 32'd0;
            exc_d   = 1'b1;
          end
        end
        DONE: begin
          if (bus.wb_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= 6'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      is_div_q <= 1'b0;
      rd_q     <= 5'd0;
      data_q   <= 32'd0;
      exc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      is_div_q <= is_div_d;
      rd_q     <= rd_d;
      data_q   <= data_d;
      exc_q    <= exc_d;
    end
  end

endmodule

// File: tb/tb_multdiv_issue.sv
// Self-checking bench for multdiv_issue: vector table, random ops against a
// transaction-level model, and hand-written flush/reset sequences.
module tb_multdiv_issue;
  localparam int TO = 40;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  multdiv_issue_if bus ();

  multdiv_issue #(.TIMEOUT(TO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int total = 0;
  int bad = 0;
  int n_start = 0;

  always @(negedge clk) if (bus.unit_start === 1'b1) n_start++;

  typedef struct {
    bit          is_div;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    int          d;      // WAIT cycle index at which unit_rdy fires; >= TO means never
    bit          uexc;
    int          stall;  // cycles wb_ready stays low in DONE
    bit          rs;     // spurious unit_rdy during START
    logic [31:0] ed;
    bit          ee;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] unit_calc(input bit is_div, input logic [31:0] a,
                                            input logic [31:0] b);
    longint r;
    if (is_div) begin
      if (b == 32'd0) return 32'hffff_ffff;
      r = longint'($signed(a)) / longint'($signed(b));
    end else begin
      r = longint'($signed(a)) * longint'($signed(b));
    end
    return r[31:0];
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    bus.op_valid = 0; bus.op_is_div = 0; bus.operand_a = 0; bus.operand_b = 0;
    bus.op_rd = 0; bus.flush = 0; bus.unit_result = 0; bus.unit_exception = 0;
    bus.unit_rdy = 0; bus.wb_ready = 0;
  endtask

  // Plays one transaction; starts and ends at posedge+1.
  task automatic run_op(input vec_t v, input string tag);
    int s0;
    bit dz;
    logic [31:0] ures;
    dz = v.is_div && (v.b == 32'd0);
    ures = unit_calc(v.is_div, v.a, v.b);
    s0 = n_start;
    bus.op_valid = 1; bus.op_is_div = v.is_div; bus.operand_a = v.a;
    bus.operand_b = v.b; bus.op_rd = v.rd;
    @(negedge clk);
    chk({tag, " accept"}, {bus.op_ready, bus.busy, bus.wb_valid}, 3'b100);
    next_cycle();
    bus.op_valid = 0; bus.operand_a = $urandom; bus.operand_b = $urandom; bus.op_rd = 5'h1f;
    if (!dz) begin
      if (v.rs) begin
        bus.unit_rdy = 1; bus.unit_result = 32'hdead_beef; bus.unit_exception = 1;
      end
      @(negedge clk);
      chk({tag, " start"}, {bus.unit_start, bus.busy, bus.wb_valid, bus.unit_is_div},
          {3'b110, v.is_div});
      chk({tag, " unit_a"}, bus.unit_a, v.a);
      chk({tag, " unit_b"}, bus.unit_b, v.b);
      next_cycle();
      bus.unit_rdy = 0; bus.unit_result = 0; bus.unit_exception = 0;
      for (int i = 0; i < TO; i++) begin
        if (i == v.d) begin
          bus.unit_rdy = 1; bus.unit_result = ures; bus.unit_exception = v.uexc;
        end
        @(negedge clk);
        chk({tag, " wait"}, {bus.wb_valid, bus.unit_start, bus.busy, bus.op_ready}, 4'b0010);
        next_cycle();
        bus.unit_rdy = 0; bus.unit_result = 0; bus.unit_exception = 0;
        if (i == v.d) break;
      end
    end
    for (int j = 0; j <= v.stall; j++) begin
      bus.wb_ready = (j == v.stall);
      @(negedge clk);
      chk({tag, " done"}, {bus.wb_valid, bus.op_ready, bus.busy}, 3'b101);
      chk({tag, " wb_data"}, bus.wb_data, v.ed);
      chk({tag, " wb_rd/exc"}, {bus.wb_rd, bus.wb_exception}, {v.rd, v.ee});
      chk({tag, " hold_a"}, bus.unit_a, v.a);
      next_cycle();
    end
    bus.wb_ready = 0;
    chk({tag, " starts"}, 64'(n_start - s0), dz ? 64'd0 : 64'd1);
    @(negedge clk);
    chk({tag, " idle"}, {bus.wb_valid, bus.busy, bus.op_ready}, 3'b001);
    next_cycle();
  endtask

  initial begin
    vec_t v;
    int s0;
    vt[0] = '{0, 32'd3, 32'd2, 5'd5, 15, 0, 0, 0, 32'd6, 0};
    vt[1] = '{1, 32'd7, 32'd0, 5'd3, 0, 0, 0, 0, 32'd0, 1};
    vt[2] = '{0, -32'sd4, 32'd5, 5'd9, 3, 0, 5, 0, 32'hffff_ffec, 0};
    vt[3] = '{0, 32'd1, 32'd1, 5'd1, TO, 0, 1, 0, 32'd0, 1};
    vt[4] = '{1, 32'd100, 32'd7, 5'd4, TO - 1, 1, 0, 0, 32'd14, 1};
    vt[5] = '{1, -32'sd9, 32'd2, 5'd7, 0, 0, 2, 1, 32'hffff_fffc, 0};
    vt[6] = '{0, 32'h1234_5678, 32'h10, 5'd30, 5, 0, 0, 0, 32'h2345_6780, 0};
    vt[7] = '{1, 32'h8000_0000, 32'hffff_ffff, 5'd2, 1, 1, 0, 0, 32'h8000_0000, 1};

    quiet_inputs();
    #2;
    chk("rst_flags", {bus.op_ready, bus.busy, bus.unit_start, bus.wb_valid, bus.wb_exception},
        5'b0);
    chk("rst_data", {bus.wb_data, bus.unit_a}, 64'd0);
    #10 reset_n = 1;
    @(negedge clk);
    chk("rst_release", {bus.op_ready, bus.busy, bus.wb_valid}, 3'b100);
    next_cycle();

    for (int k = 0; k < 8; k++) run_op(vt[k], $sformatf("vec%0d", k));

    // Flush in WAIT, unit answers two cycles later and must be ignored.
    s0 = n_start;
    bus.op_valid = 1; bus.operand_a = 32'd11; bus.operand_b = 32'd3; bus.op_rd = 5'd8;
    next_cycle();
    bus.op_valid = 0;
    next_cycle();
    next_cycle();
    bus.flush = 1;
    @(negedge clk);
    chk("flush_cycle", {bus.op_ready, bus.busy, bus.unit_start}, 3'b010);
    next_cycle();
    bus.flush = 0;
    @(negedge clk);
    chk("flush_idle", {bus.busy, bus.wb_valid, bus.op_ready}, 3'b001);
    next_cycle();
    bus.unit_rdy = 1; bus.unit_result = 32'd33;
    @(negedge clk);
    chk("late_rdy", {bus.busy, bus.wb_valid}, 2'b00);
    next_cycle();
    bus.unit_rdy = 0;
    @(negedge clk);
    chk("late_rdy_after", {bus.busy, bus.wb_valid, bus.op_ready}, 3'b001);
    chk("flush_starts", 64'(n_start - s0), 64'd1);
    next_cycle();

    // Op presented together with flush is dropped.
    s0 = n_start;
    bus.op_valid = 1; bus.flush = 1; bus.operand_b = 32'd5;
    @(negedge clk);
    chk("flush_op_ready", bus.op_ready, 1'b0);
    next_cycle();
    bus.op_valid = 0; bus.flush = 0;
    @(negedge clk);
    chk("flush_drop", {bus.busy, bus.unit_start}, 2'b00);
    next_cycle();
    chk("flush_drop_starts", 64'(n_start - s0), 64'd0);

    // Flush while holding a result in DONE.
    bus.op_valid = 1; bus.op_is_div = 1; bus.operand_a = 32'd9; bus.operand_b = 32'd0;
    next_cycle();
    bus.op_valid = 0; bus.op_is_div = 0; bus.flush = 1;
    @(negedge clk);
    chk("done_pre_flush", bus.wb_valid, 1'b1);
    next_cycle();
    bus.flush = 0;
    @(negedge clk);
    chk("done_flushed", {bus.wb_valid, bus.busy}, 2'b00);
    next_cycle();

    // Asynchronous reset in WAIT.
    bus.op_valid = 1; bus.operand_a = 32'hcafe; bus.operand_b = 32'h77; bus.op_rd = 5'd12;
    next_cycle();
    bus.op_valid = 0;
    next_cycle();
    next_cycle();
    #2 reset_n = 0;
    #1;
    chk("arst_flags", {bus.op_ready, bus.busy, bus.unit_start, bus.unit_is_div, bus.wb_valid,
                       bus.wb_exception}, 6'b0);
    chk("arst_ops", {bus.unit_a, bus.unit_b}, 64'd0);
    chk("arst_wb", {bus.wb_data, 27'd0, bus.wb_rd}, 64'd0);
    #3 reset_n = 1;
    #1;
    chk("arst_release", {bus.op_ready, bus.busy}, 2'b10);
    next_cycle();
    s0 = n_start;
    bus.unit_rdy = 1; bus.unit_result = 32'h55;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("arst_quiet", {bus.wb_valid, bus.busy, bus.op_ready}, 3'b001);
      next_cycle();
      bus.unit_rdy = 0;
    end
    chk("arst_starts", 64'(n_start - s0), 64'd0);

    // Random ops against the transaction-level model.
    for (int k = 0; k < 30; k++) begin
      v.is_div = 1'($urandom);
      v.a = $urandom;
      v.b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if (v.b == 32'd0 && !v.is_div) v.b = 32'd3;
      v.rd = 5'($urandom);
      v.d = ($urandom_range(0, 7) == 0) ? TO : int'($urandom_range(0, 12));
      v.uexc = 1'($urandom);
      v.stall = int'($urandom_range(0, 3));
      v.rs = 1'($urandom);
      if (v.is_div && v.b == 32'd0) begin
        v.ed = 32'd0; v.ee = 1;
      end else if (v.d >= TO) begin
        v.ed = 32'd0; v.ee = 1;
      end else begin
        v.ed = unit_calc(v.is_div, v.a, v.b); v.ee = v.uexc;
      end
      run_op(v, $sformatf("rnd%0d", k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
